// File: rtl/avalon_wait_memory.sv
// Avalon-MM word memory with fixed or LFSR-random wait states, byte lanes
// and an error pulse for out-of-range, unaligned or read+write requests.
module avalon_wait_memory #(
   parameter int unsigned DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
   parameter int unsigned WAIT_MODE   = 0,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned WAIT_BITS   = 3,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [3:0]  byteenable,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        waitrequest,
   output logic        error
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = (WAIT_BITS > 4) ? WAIT_BITS : 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [15:0]   lfsr;
   logic          do_write;
   logic [31:0]   mem [DEPTH];

   logic [31:0]   idx;
   logic [AW-1:0] widx;
   logic          req;
   logic          bad;
   logic [31:0]   lane_mask;
   logic [31:0]   ack_rdata;
   logic [CW-1:0] wait_load;
   logic          feedback;

   always_comb begin
      idx       = (addr - BASE_ADDR) >> 2;
      widx      = idx[AW-1:0];
      req       = read | write;
      bad       = (idx >= 32'(DEPTH)) || (addr[1:0] != 2'b00) || (read && write);
      lane_mask = {{8{byteenable[3]}}, {8{byteenable[2]}},
                   {8{byteenable[1]}}, {8{byteenable[0]}}};
      ack_rdata = (read && !bad) ? (mem[widx] & lane_mask) : '0;
      wait_load = (WAIT_MODE == 0) ? CW'(WAIT_CYCLES) : CW'(lfsr[WAIT_BITS-1:0]);
      feedback  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   end

   // ACK is entered either straight from IDLE (W=0) or from the last WAIT
   // cycle; both paths register the read data and error flag identically.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         waitrequest <= 1'b1;
         readdata    <= '0;
         error       <= 1'b0;
         count       <= '0;
         lfsr        <= SEED;
         do_write    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               waitrequest <= 1'b1;
               readdata    <= '0;
               error       <= 1'b0;
               do_write    <= 1'b0;
               if (req) begin
                  count <= wait_load;
                  if (wait_load != '0) begin
                     state <= S_WAIT;
                  end else begin
                     state       <= S_ACK;
                     waitrequest <= 1'b0;
                     readdata    <= ack_rdata;
                     error       <= bad;
                     do_write    <= write && !bad;
                  end
               end
            end
            S_WAIT: begin
               if (!req) begin
                  state <= S_IDLE;
                  count <= '0;
               end else if (count <= CW'(1)) begin
                  state       <= S_ACK;
                  count       <= '0;
                  waitrequest <= 1'b0;
                  readdata    <= ack_rdata;
                  error       <= bad;
                  do_write    <= write && !bad;
               end else begin
                  count <= count - CW'(1);
               end
            end
            S_ACK: begin
               state       <= S_IDLE;
               waitrequest <= 1'b1;
               readdata    <= '0;
               error       <= 1'b0;
               do_write    <= 1'b0;
               lfsr        <= {lfsr[14:0], feedback};
            end
            default: begin
               state       <= S_IDLE;
               waitrequest <= 1'b1;
               readdata    <= '0;
               error       <= 1'b0;
               do_write    <= 1'b0;
            end
         endcase
      end
   end

   // Address and write data are still held by the master during ACK.
   always_ff @(posedge clk) begin
      if (state == S_ACK && do_write) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (byteenable[b]) mem[widx][8*b +: 8] <= writedata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_avalon_wait_memory.sv
// Scoreboard bench: three memories (fixed 2 waits, fixed 0 waits, random waits)
// driven one at a time and checked against a behavioural memory/LFSR model.
module tb_avalon_wait_memory;

   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'hBFC00000;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd   [3];
   logic        wr   [3];
   logic [31:0] ad   [3];
   logic [3:0]  be   [3];
   logic [31:0] wd   [3];
   logic [31:0] rdat [3];
   logic        wreq [3];
   logic        err  [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      avalon_wait_memory #(
         .DEPTH      (DEPTH),
         .BASE_ADDR  (BASE),
         .WAIT_MODE  ((g == 2) ? 1 : 0),
         .WAIT_CYCLES((g == 0) ? 2 : 0),
         .WAIT_BITS  (3),
         .SEED       (SEED)
      ) u_dut (
         .clk        (clk),
         .reset      (reset),
         .read       (rd[g]),
         .write      (wr[g]),
         .addr       (ad[g]),
         .byteenable (be[g]),
         .writedata  (wd[g]),
         .readdata   (rdat[g]),
         .waitrequest(wreq[g]),
         .error      (err[g])
      );
   end

   typedef struct packed {
      logic [1:0]  k;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mdl [3][DEPTH];
   logic [15:0] mlfsr;
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  seen = '0;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], ^(l & 16'hB400)};
   endfunction

   function automatic logic [31:0] mask_of(input logic [3:0] b);
      logic [31:0] m = '0;
      for (int i = 0; i < 4; i++) if (b[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   // caller is at posedge+1; returns at posedge+1 of the cycle after ACK
   task automatic xfer(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, output int lat);
      exp_t        e;
      logic [31:0] m;
      int          off;
      int          i;
      logic        bad;
      int          expw;
      logic        done;
      m    = mask_of(b);
      off  = int'(a - BASE);
      i    = int'((a - BASE) / 4);
      bad  = (a % 4 != 0) || ((a - BASE) / 4 >= DEPTH) || (r && w);
      e.k     = 2'(k);
      e.err   = bad;
      e.rdata = (!bad && r) ? (mdl[k][i] & m) : 32'h0;
      if (!bad && w) mdl[k][i] = (mdl[k][i] & ~m) | (d & m);
      expw = (k == 0) ? 2 : (k == 1) ? 0 : int'(mlfsr[2:0]);
      sbq.push_back(e);
      rd[k] = r; wr[k] = w; ad[k] = a; be[k] = b; wd[k] = d;
      lat  = 0;
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (!wreq[k]) done = 1'b1;
         else lat++;
      end
      checks++;
      if (!done || lat != expw + 1) begin
         errors++;
         $display("FAIL latency inst=%0d addr=%h off=%0d got=%0d exp=%0d", k, a, off, lat, expw + 1);
      end
      if (k == 2) begin
         if (lat >= 1 && lat <= 8) seen[lat-1] = 1'b1;
         mlfsr = lfsr_step(mlfsr);
      end
      @(posedge clk); #1;
      rd[k] = 1'b0; wr[k] = 1'b0;
   endtask

   task automatic rand_xfer(input int k);
      int          i;
      int          lat;
      logic        r;
      logic        w;
      logic [31:0] a;
      i = $urandom_range(0, DEPTH);
      r = 1'($urandom_range(0, 1));
      w = !r || ($urandom_range(0, 19) == 0);
      a = BASE + 32'(4 * i) + (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
      xfer(k, r, w, a, 4'($urandom), $urandom, lat);
   endtask

   task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (!wreq[k]) begin
               if (sbq.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_ack inst=%0d got=ack exp=none", k);
               end else begin
                  e = sbq.pop_front();
                  if (int'(e.k) != k || rdat[k] !== e.rdata || err[k] !== e.err) begin
                     errors++;
                     $display("FAIL ack inst=%0d got=%h/err%b exp=%h/err%b (inst %0d)",
                              k, rdat[k], err[k], e.rdata, e.err, e.k);
                  end
               end
            end else if (err[k] !== 1'b0 || rdat[k] !== 32'h0) begin
               errors++;
               $display("FAIL idle_outputs inst=%0d got=%h/err%b exp=0/err0", k, rdat[k], err[k]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      reset = 1'b1;
      mlfsr = SEED;
      for (int k = 0; k < 3; k++) begin
         rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = '0; be[k] = '0; wd[k] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check1("reset_waitrequest", 32'(wreq[k]), 32'd1);
         check1("reset_readdata", rdat[k], 32'h0);
         check1("reset_error", 32'(err[k]), 32'd0);
      end
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;

      for (int k = 0; k < 3; k++)
         for (int i = 0; i < DEPTH; i++)
            xfer(k, 1'b0, 1'b1, BASE + 32'(4 * i), 4'hF, $urandom, lat);

      // fixed two waits, full word then byte lanes
      xfer(0, 1'b0, 1'b1, 32'hBFC00010, 4'hF, 32'hDEADBEEF, lat);
      xfer(0, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, lat);
      xfer(0, 1'b0, 1'b1, 32'hBFC00010, 4'b0101, 32'h11223344, lat);
      xfer(0, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, lat);
      xfer(0, 1'b1, 1'b0, 32'hBFC00010, 4'b0011, 32'h0, lat);
      check1("model_bytelane", mdl[0][4], 32'hDE22BE44);

      // zero waits, back-to-back
      for (int i = 0; i < 4; i++) xfer(1, 1'b1, 1'b0, BASE + 32'(4 * i), 4'hF, 32'h0, lat);

      // bad requests
      for (int k = 0; k < 2; k++) begin
         xfer(k, 1'b1, 1'b0, BASE + 32'(4 * DEPTH), 4'hF, 32'h0, lat);
         xfer(k, 1'b0, 1'b1, 32'hBFC00002, 4'hF, 32'h55555555, lat);
         xfer(k, 1'b1, 1'b1, 32'hBFC00010, 4'hF, 32'hAAAAAAAA, lat);
         xfer(k, 1'b1, 1'b0, 32'hBFC00000, 4'hF, 32'h0, lat);
         xfer(k, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, lat);
      end

      // random waits
      for (int n = 0; n < 200; n++) rand_xfer(2);
      check1("wait_span", 32'(seen), 32'hFF);

      // reset during WAIT of a write
      wr[0] = 1'b1; ad[0] = 32'hBFC00020; be[0] = 4'hF; wd[0] = 32'hCAFEF00D;
      @(posedge clk); #1 reset = 1'b1;
      #1 check1("reset_in_wait", 32'(wreq[0]), 32'd1);
      wr[0] = 1'b0;
      mlfsr = SEED;
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      xfer(0, 1'b1, 1'b0, 32'hBFC00020, 4'hF, 32'h0, lat);

      // reset during ACK of a zero-wait write
      wr[1] = 1'b1; ad[1] = 32'hBFC00020; be[1] = 4'hF; wd[1] = 32'h0BADF00D;
      @(posedge clk); #1 reset = 1'b1;
      #1 check1("reset_in_ack", 32'(wreq[1]), 32'd1);
      wr[1] = 1'b0;
      mlfsr = SEED;
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      xfer(1, 1'b1, 1'b0, 32'hBFC00020, 4'hF, 32'h0, lat);

      // wait sequence restarts from the seed
      for (int n = 0; n < 30; n++) rand_xfer(2);

      // request withdrawn during WAIT has no effect
      wr[0] = 1'b1; ad[0] = 32'hBFC00024; be[0] = 4'hF; wd[0] = 32'h12345678;
      @(posedge clk); #1 wr[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      xfer(0, 1'b1, 1'b0, 32'hBFC00024, 4'hF, 32'h0, lat);

      repeat (2) @(posedge clk);
      check1("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
